// File: rtl/ros2_pub_msg_loader.sv
// ---------------------------------------------------------------------------
// ros2_pub_msg_loader
//
// Collects a publisher message byte-by-byte into a shadow buffer. On the
// final byte it requests the ros2_ether app-data grant. It then commits the
// whole buffer plus its length to the flat output vector in a single cycle,
// and pulses a one-cycle release. A partially filled buffer is never visible
// on pub_app_data.
//
// Optional feature macro: ROS2_PUB_LOADER_NUL_TERM_EN
//   defined   : the buffer holds MAX_LEN-1 payload bytes. A 0x00 terminator
//               follows the payload and is counted in pub_app_data_len.
//   undefined : the buffer holds MAX_LEN payload bytes and len = n.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   s_data/s_valid/
//   s_last/s_ready      byte stream input (valid/ready)
//   pub_app_data        committed message, byte i at [8i+7:8i]
//   pub_app_data_len    committed length in bytes
//   pub_app_data_req    grant request to ros2_ether
//   pub_app_data_grant  grant from ros2_ether (only looked at while requesting)
//   pub_app_data_rel    one-cycle release strobe after commit
//   busy                high outside the FILL state
//   overflow            current message lost bytes past capacity
//   msg_count           number of committed messages, wraps at 16 bits
// ---------------------------------------------------------------------------
`ifndef ROS2_MAX_APP_DATA_LEN
`define ROS2_MAX_APP_DATA_LEN 32
`endif

module ros2_pub_msg_loader #(
  parameter int MAX_LEN = `ROS2_MAX_APP_DATA_LEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [MAX_LEN*8-1:0] pub_app_data,
  output logic [7:0]           pub_app_data_len,
  output logic                 pub_app_data_req,
  input  logic                 pub_app_data_grant,
  output logic                 pub_app_data_rel,
  output logic                 busy,
  output logic                 overflow,
  output logic [15:0]          msg_count
);

`ifdef ROS2_PUB_LOADER_NUL_TERM_EN
  localparam int       CAP     = MAX_LEN - 1;
  localparam logic [7:0] LEN_ADD = 8'd1;
`else
  localparam int       CAP     = MAX_LEN;
  localparam logic [7:0] LEN_ADD = 8'd0;
`endif

  localparam int PW = $clog2(MAX_LEN + 1);
  localparam logic [PW-1:0] CAP_W = PW'(CAP);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        n_q, n_d;
  logic [MAX_LEN*8-1:0] shadow_q;
  logic [MAX_LEN*8-1:0] data_q, data_d;
  logic [MAX_LEN*8-1:0] commit_data;
  logic [7:0]           len_q, len_d;
  logic                 req_q, req_d;
  logic                 rel_q, rel_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 beat;
  logic                 wr_en;

  assign s_ready = (state_q == ST_FILL);
  assign busy    = (state_q != ST_FILL);
  assign beat    = s_valid && s_ready;
  assign wr_en   = beat && (wptr_q < CAP_W);

  assign pub_app_data     = data_q;
  assign pub_app_data_len = len_q;
  assign pub_app_data_req = req_q;
  assign pub_app_data_rel = rel_q;
  assign overflow         = ovf_q;
  assign msg_count        = cnt_q;

  // Bytes at or beyond n are forced to zero so stale shadow contents from a
  // longer earlier message never leak out; this also supplies the terminator.
  always_comb begin
    commit_data = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (PW'(i) < n_q) commit_data[8*i +: 8] = shadow_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    n_d     = n_q;
    data_d  = data_q;
    len_d   = len_q;
    req_d   = req_q;
    rel_d   = 1'b0;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_FILL: begin
        if (beat) begin
          // First beat of a new message clears the previous truncation flag.
          if (wptr_q == '0) ovf_d = 1'b0;
          if (wr_en) wptr_d = wptr_q + 1'b1;
          else       ovf_d  = 1'b1;
          if (s_last) begin
            n_d     = wptr_d;
            req_d   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (pub_app_data_grant) begin
          data_d  = commit_data;
          len_d   = 8'(n_q) + LEN_ADD;
          cnt_d   = cnt_q + 16'd1;
          req_d   = 1'b0;
          rel_d   = 1'b1;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        wptr_d  = '0;
        state_d = ST_FILL;
      end
      default: begin
        req_d   = 1'b0;
        wptr_d  = '0;
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      wptr_q  <= '0;
      n_q     <= '0;
      data_q  <= '0;
      len_q   <= '0;
      req_q   <= 1'b0;
      rel_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      n_q     <= n_d;
      data_q  <= data_d;
      len_q   <= len_d;
      req_q   <= req_d;
      rel_q   <= rel_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Shadow storage is pure data; bytes are only read below n, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_LEN; i++) begin
      if (wr_en && (wptr_q == PW'(i))) shadow_q[8*i +: 8] <= s_data;
    end
  end

endmodule

// File: doc/ros2_pub_msg_loader.md
# ros2_pub_msg_loader

Loads publisher application data for `ros2_ether` from a byte stream. Bytes are accepted over a valid/ready interface into a shadow buffer. On the final byte the block requests the publisher app-data grant, commits the buffer to the flat `ros2_pub_app_data` vector and length atomically, then releases the grant. It sits between user logic and the `ros2_pub_app_data*` ports, and is the writer counterpart to the subscriber's `ros2_sub_app_data*` memory-write path.

## Interface
- `MAX_LEN`, default `` `ROS2_MAX_APP_DATA_LEN ``: capacity in bytes of the app-data vector.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_data` in 8: payload byte.
- `s_valid` in 1: `s_data` is valid.
- `s_last` in 1: the current beat is the final byte of the message.
- `s_ready` out 1: the block accepts a beat.
- `pub_app_data` out MAX_LEN*8: committed message; byte i is at bits [8i+7:8i].
- `pub_app_data_len` out 8: committed length in bytes.
- `pub_app_data_req` out 1: grant request to `ros2_ether`.
- `pub_app_data_grant` in 1: grant from `ros2_ether`.
- `pub_app_data_rel` out 1: single-cycle release strobe.
- `busy` out 1: high while not in FILL.
- `overflow` out 1: the current message was truncated.
- `msg_count` out 16: count of committed messages; wraps.

## Operation
- States: FILL, REQ, REL. Reset state is FILL.
- **FILL**
  - `s_ready`=1.
  - An accepted beat (`s_valid & s_ready`) with `wptr < CAP` writes `shadow[wptr]` and increments `wptr`.
  - An accepted beat with `wptr == CAP` is dropped and sets `overflow`.
  - An accepted beat with `s_last`=1 moves to REQ and latches `n = wptr` after that beat's write.
  - Every beat carries a byte, so n ≥ 1.
- **REQ**
  - `s_ready`=0, `pub_app_data_req`=1.
  - Waits an unbounded time for `pub_app_data_grant`=1.
  - At the edge where grant is sampled high:
    - bytes 0..n-1 of `pub_app_data` are loaded from shadow;
    - all bytes ≥ n are loaded with 0x00;
    - `pub_app_data_len` is loaded;
    - `msg_count` increments (0xFFFF→0x0000);
    - state moves to REL.
- **REL**
  - `pub_app_data_req`=0, `pub_app_data_rel`=1 for exactly one cycle, then FILL with `wptr`=0.
- `pub_app_data_grant` is ignored outside REQ.
- `overflow` stays high from the cycle after the first dropped beat until the first beat of the next message is accepted.
- `pub_app_data` and `pub_app_data_len` change only in the commit cycle. A partially filled shadow buffer never appears on the outputs.

## Timing
- Reset values:
  - `pub_app_data`=0, `pub_app_data_len`=0, `msg_count`=0.
  - `pub_app_data_req`=0, `pub_app_data_rel`=0, `overflow`=0, `busy`=0.
  - `s_ready`=1.
- `s_ready` and `busy` decode the state combinationally. All other outputs are registered.
- Throughput in FILL: one byte per cycle.
- Last beat accepted at edge T:
  - `pub_app_data_req`=1 and `s_ready`=0 from T+1.
  - If grant is high in cycle T+1, the new data and length are visible and `rel`=1 from T+2.
  - `s_ready`=1 again from T+3.
- Minimum message period: n+2 cycles.
- Reset asserted mid-message or in REQ/REL:
  - all outputs take their reset values immediately;
  - the pending message is discarded;
  - no `rel` is emitted.

## Configuration
- `ROS2_PUB_LOADER_NUL_TERM_EN`
  - Defined: CAP = MAX_LEN-1. The commit appends byte 0x00 at index n and `pub_app_data_len` = n+1, matching the ROS2 string serialization that includes the terminator.
  - Undefined: CAP = MAX_LEN and `pub_app_data_len` = n.

## Test plan
- Stream "hello" (0x68 0x65 0x6C 0x6C 0x6F) with `s_last` on 0x6F, grant tied high:
  - `pub_app_data[39:0]`=0x6F6C6C6568;
  - with `_EN`, len=6 and byte 5=0x00; without `_EN`, len=5;
  - `req` high for 1 cycle, `rel` pulses once 2 cycles after `s_last`.
- Hold grant low for 20 cycles after `s_last`:
  - `req` stays high;
  - `s_ready`=0 throughout;
  - the old `pub_app_data` is unchanged until the cycle after grant rises.
- Send MAX_LEN+3 bytes (with `_EN`):
  - `overflow`=1 after byte MAX_LEN;
  - len=MAX_LEN, last payload byte is the (MAX_LEN-1)th input byte;
  - `overflow` clears on the next message's first beat.
- Send a 10-byte message, then a 3-byte message:
  - bytes 3..MAX_LEN-1 are zero after the second commit;
  - `msg_count`=2.
- Assert `rst_n`=0 while in REQ:
  - `req`=0, len=0, `pub_app_data`=0 immediately;
  - after release, `s_ready`=1 and a new 1-byte message commits normally.
